// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter using reverse double-dabble:
// one right shift per cycle with a subtract-3 correction on every digit.
module bcd2bin_seq #(
  parameter int N      = 8,
  // Decimal digit count of 2**N: floor(N*log10(2)) + 1.
  parameter int DIGITS = (N * 30103) / 100000 + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          bin_out,
  output logic                  ovf,
  output logic                  err
);

  localparam int B  = $clog2(10 ** DIGITS);
  localparam int W  = 4 * DIGITS + B;
  localparam int CW = $clog2(B + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    sr_q;
  logic [W-1:0]    sr_step;
  logic [CW-1:0]   cnt_q;
  logic            err_q;
  logic            accept;
  logic            last_shift;
  logic            bad_digit;
  logic [B-1:0]    result;

  assign accept     = (state_q == IDLE) && in_ready && in_valid;
  assign last_shift = (state_q == BUSY) && (cnt_q == CW'(1));
  assign result     = sr_step[B-1:0];

  always_comb begin
    bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // One reverse double-dabble step: shift right, then pull every digit
  // that landed at 8 or above back into decimal range.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sr_step = sr_q >> 1;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr_step[B + 4*d +: 4] >= 4'd8)
        sr_step[B + 4*d +: 4] = sr_step[B + 4*d +: 4] - 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)     state_d = BUSY;
      BUSY:    if (last_shift) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // in_ready/out_valid are registered from the next state so reset holds
  // both low and in_ready rises only on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      sr_q      <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      bin_out   <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      if (accept) begin
        sr_q  <= {bcd_in, {B{1'b0}}};
        cnt_q <= CW'(B);
        err_q <= bad_digit;
      end else if (state_q == BUSY) begin
        sr_q  <= sr_step;
        cnt_q <= cnt_q - CW'(1);
        if (last_shift) begin
          if (err_q) begin
            bin_out <= '0;
            ovf     <= 1'b0;
            err     <= 1'b1;
          end else if (|result[B-1:N]) begin
            bin_out <= '1;
            ovf     <= 1'b1;
            err     <= 1'b0;
          end else begin
            bin_out <= result[N-1:0];
            ovf     <= 1'b0;
            err     <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
- Sequential BCD-to-binary converter; the inverse of the bin2bcd block.
- Accepts a packed BCD word over a valid/ready handshake.
- Converts it iteratively with reverse double-dabble: one right shift per cycle, then a subtract-3 correction on each digit.
- Returns an N-bit binary result with overflow and invalid-digit flags.
- Sits on the parsing/input side of any datapath that consumes decimal data for bin2bcd-based display logic.

Parameters:
- N, 8, binary output width.
- DIGITS, ceil(log10(2**N)), number of BCD digits on input. Default is 3 for N=8, the same digit count bin2bcd emits.
- B (localparam), ceil(log2(10**DIGITS)), internal result width and iteration count. B=10 for DIGITS=3.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  bcd_in is valid
- in_ready  out  1  block can accept an input this cycle
- bcd_in  in  4*DIGITS  packed BCD; digit 0 in bits [3:0]
- out_valid  out  1  result fields are valid
- out_ready  in  1  consumer accepts the result
- bin_out  out  N  binary result
- ovf  out  1  decimal value exceeds 2**N-1
- err  out  1  at least one input nibble was greater than 9

Behaviour:
- Reset is one clock; rst_n is asynchronous and active-low.
  - While rst_n=0: state=IDLE, in_ready=0, out_valid=0, bin_out=0, ovf=0, err=0, shift register=0, counter=0.
  - in_ready goes to 1 on the first clk edge after rst_n deasserts.
  - rst_n asserted at any point, including mid-BUSY or in DONE, aborts the conversion immediately. No result is emitted.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On a clk edge with in_valid=1, the input is accepted.
  - On accept: load the shift register {bcd_in, B'b0}, set the counter to B, latch err_r = (any nibble > 9), then go to BUSY.
- State BUSY:
  - in_ready=0.
  - Each edge: shift the whole (4*DIGITS+B)-bit register right by 1. Then, for each BCD digit of the shifted value, if digit >= 8, subtract 3.
  - Decrement the counter each edge. When it reaches 0 (after exactly B shift edges), go to DONE.
  - in_valid is ignored while in BUSY.
- State DONE:
  - out_valid=1.
  - The result R is the low B bits of the register.
  - If err_r: bin_out=0, ovf=0, err=1.
  - Else if R > 2**N-1: bin_out = all ones (saturate), ovf=1, err=0.
  - Else: bin_out = R[N-1:0], ovf=0, err=0.
  - The output fields are registered and held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1: clear out_valid and go to IDLE.
  - in_ready stays 0 in DONE, so there is no accept in the same cycle as the handoff.
- Latency and throughput:
  - out_valid rises B edges after the accept edge: 10 cycles for the defaults.
  - Minimum spacing between accepts is B+2 cycles.
  - Latency is the same for valid, invalid and overflowing inputs.
- Digit corrections apply to all DIGITS nibbles every BUSY cycle. With a valid input, nibble values never exceed 12 after the shift, so no digit underflows.
- Invalid nibbles are processed normally. Their result is discarded and replaced by bin_out=0 with err=1.
- out_ready is ignored outside DONE.

Test Plan:
- Reset, then bcd_in=12'h000 with in_valid=1 -> out_valid exactly 10 cycles after accept; bin_out=8'h00, ovf=0, err=0.
- Sweep bcd_in = BCD(0..255), one at a time, with out_ready tied to 1 -> bin_out equals the decimal value for each input (e.g. 12'h255 -> 8'hFF, 12'h128 -> 8'h80); ovf=0, err=0 throughout.
- bcd_in=12'h256 and 12'h999 -> bin_out=8'hFF, ovf=1, err=0 for both.
- bcd_in=12'h1A5 -> bin_out=8'h00, err=1, ovf=0, with the same 10-cycle latency.
- Backpressure: bcd_in=12'h042, out_ready held 0 for 5 cycles after out_valid -> bin_out stays 8'h2A and in_ready stays 0. Raising out_ready gives a single-cycle handoff, then in_ready=1 on the next cycle.
- Assert rst_n low 4 cycles into BUSY -> out_valid, bin_out, ovf and err all go to 0 immediately. After release, a new input 12'h007 converts to 8'h07 with no stale result emitted.
